layer_line_buffer_db: RTL and testbench

LAYER_LINE_BUFFER_DB -- requirements
Module: layer_line_buffer_db

---
 rtl/layer_line_buffer_db_if.sv | 45 ++++
 rtl/layer_line_buffer_db.sv | 120 ++++++++++++
 tb/tb_layer_line_buffer_db.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/layer_line_buffer_db_if.sv
// rtl/layer_line_buffer_db_if.sv - renderer/composer port bundle for the double-buffered line buffer
interface layer_line_buffer_db_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 10
);
    logic                  swap_req;
    logic                  clear_en;
    logic                  skip_transparent;
    logic [IDX_WIDTH-1:0]  renderer_wr_idx;
    logic [DATA_WIDTH-1:0] renderer_wr_data;
    logic                  renderer_wr_en;
    logic                  renderer_ready;
    logic [IDX_WIDTH-1:0]  composer_rd_idx;
    logic [DATA_WIDTH-1:0] composer_rd_data;
    logic                  active_render_buffer;
    logic                  wr_dropped;

    modport master (
        output swap_req,
        output clear_en,
        output skip_transparent,
        output renderer_wr_idx,
        output renderer_wr_data,
        output renderer_wr_en,
        output composer_rd_idx,
        input  renderer_ready,
        input  composer_rd_data,
        input  active_render_buffer,
        input  wr_dropped
    );

    modport slave (
        input  swap_req,
        input  clear_en,
        input  skip_transparent,
        input  renderer_wr_idx,
        input  renderer_wr_data,
        input  renderer_wr_en,
        input  composer_rd_idx,
        output renderer_ready,
        output composer_rd_data,
        output active_render_buffer,
        output wr_dropped
    );
endinterface

// File: rtl/layer_line_buffer_db.sv
// rtl/layer_line_buffer_db.sv - double-buffered layer line buffer with background clear engine
module layer_line_buffer_db #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    IDX_WIDTH   = 10,
    parameter int                    LINE_LEN    = 640,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_line_buffer_db_if.slave bus
);
    localparam int                 AW       = IDX_WIDTH + 1;
    localparam int                 DEPTH    = 2 * LINE_LEN;
    localparam logic [AW-1:0]      LEN_W    = AW'(LINE_LEN);
    localparam logic [IDX_WIDTH:0] LAST_CNT = (IDX_WIDTH + 1)'(LINE_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    logic                  active_buf;
    logic                  ready_q;
    logic                  dropped_q;
    logic [IDX_WIDTH:0]    clr_cnt;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_idx_ok;
    logic                  rd_idx_ok;
    logic                  transparent;
    logic                  rend_accept;
    logic                  clear_wr;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [AW-1:0]         rd_addr;

    // Buffer 0 occupies [0, LINE_LEN), buffer 1 occupies [LINE_LEN, 2*LINE_LEN).
    function automatic logic [AW-1:0] buf_addr(input logic sel, input logic [AW-1:0] idx);
        return sel ? (LEN_W + idx) : idx;
    endfunction

    always_comb begin
        wr_idx_ok   = {1'b0, bus.renderer_wr_idx} < LEN_W;
        rd_idx_ok   = {1'b0, bus.composer_rd_idx} < LEN_W;
        transparent = bus.skip_transparent && (bus.renderer_wr_data == '0);
        rend_accept = bus.renderer_wr_en && ready_q && wr_idx_ok && !transparent;
        clear_wr    = (state == CLEAR);
        // The clear engine and the renderer never write together: ready_q is low in CLEAR.
        mem_we      = !rst && (rend_accept || clear_wr);
        mem_waddr   = clear_wr ? buf_addr(active_buf, clr_cnt)
                               : buf_addr(active_buf, {1'b0, bus.renderer_wr_idx});
        mem_wdata   = clear_wr ? CLEAR_VALUE : bus.renderer_wr_data;
        rd_addr     = buf_addr(~active_buf, {1'b0, bus.composer_rd_idx});
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_idx_ok ? mem[rd_addr] : '0;
        end
    end

    // A swap always wins over clear progress; it restarts (or cancels) the clear on the new buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active_buf <= 1'b0;
            ready_q    <= 1'b1;
            dropped_q  <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            if (bus.renderer_wr_en && !ready_q) begin
                dropped_q <= 1'b1;
            end
            if (bus.swap_req) begin
                active_buf <= ~active_buf;
                clr_cnt    <= '0;
                if (bus.clear_en) begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                end else begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            end else begin
                case (state)
                    CLEAR: begin
                        if (clr_cnt == LAST_CNT) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.renderer_ready       = ready_q;
    assign bus.composer_rd_data     = rd_data_q;
    assign bus.active_render_buffer = active_buf;
    assign bus.wr_dropped           = dropped_q;
endmodule

// File: tb/tb_layer_line_buffer_db.sv
// tb/tb_layer_line_buffer_db.sv - scoreboard bench for layer_line_buffer_db
module tb_layer_line_buffer_db;
    localparam int DW  = 8;
    localparam int IW  = 10;
    localparam int LEN = 640;
    localparam logic [DW-1:0] CV = 8'h3C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_req = 1'b0;
    logic rd_pending = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    layer_line_buffer_db_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    layer_line_buffer_db #(
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW),
        .LINE_LEN   (LEN),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_pending <= rd_req;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rd_pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=%0h required=none", bus.composer_rd_data);
                end else begin
                    chk("rd_data", 32'(bus.composer_rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] d);
        bus.renderer_wr_en   = 1'b1;
        bus.renderer_wr_idx  = IW'(idx);
        bus.renderer_wr_data = d;
        step();
        bus.renderer_wr_en   = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [DW-1:0] e);
        bus.composer_rd_idx = IW'(idx);
        rd_req = 1'b1;
        exp_q.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    task automatic swap(input logic ce);
        bus.swap_req = 1'b1;
        bus.clear_en = ce;
        step();
        bus.swap_req = 1'b0;
        bus.clear_en = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.swap_req = 0; bus.clear_en = 0; bus.skip_transparent = 0;
        bus.renderer_wr_idx = '0; bus.renderer_wr_data = '0; bus.renderer_wr_en = 0;
        bus.composer_rd_idx = '0;
        fork
            monitor_loop();
        join_none

        rst = 1'b1;
        step(); step();
        chk("rst_ready", 32'(bus.renderer_ready), 1);
        chk("rst_active", 32'(bus.active_render_buffer), 0);
        chk("rst_dropped", 32'(bus.wr_dropped), 0);
        chk("rst_rd_data", 32'(bus.composer_rd_data), 0);
        rst = 1'b0;
        step();

        // basic write / swap / read
        wr(5, 8'hA5);
        swap(1'b0);
        chk("swap1_active", 32'(bus.active_render_buffer), 1);
        rd(5, 8'hA5);

        // transparency handling and out-of-range index
        wr(3, 8'h44);
        bus.skip_transparent = 1'b1;
        wr(3, 8'h00);
        bus.skip_transparent = 1'b0;
        wr(4, 8'h77);
        wr(4, 8'h00);
        wr(60, 8'h60);
        swap(1'b0);
        chk("swap2_active", 32'(bus.active_render_buffer), 0);
        rd(3, 8'h44);
        rd(4, 8'h00);
        rd(700, 8'h00);
        wr(700, 8'hEE);
        rd(60, 8'h60);
        chk("oob_dropped", 32'(bus.wr_dropped), 0);

        // write and read in the swap cycle use pre-swap buffers
        bus.swap_req = 1'b1;
        bus.renderer_wr_en = 1'b1; bus.renderer_wr_idx = 7; bus.renderer_wr_data = 8'h17;
        bus.composer_rd_idx = 3; rd_req = 1'b1; exp_q.push_back(8'h44);
        step();
        bus.swap_req = 1'b0; bus.renderer_wr_en = 1'b0; rd_req = 1'b0;
        chk("swap3_active", 32'(bus.active_render_buffer), 1);
        rd(7, 8'h17);

        // full clear of buffer 0 with a dropped write
        swap(1'b1);
        cnt = 0;
        bus.renderer_wr_en = 1'b1; bus.renderer_wr_idx = 9; bus.renderer_wr_data = 8'h99;
        while (bus.renderer_ready == 1'b0 && cnt < 2000) begin
            cnt++;
            step();
            bus.renderer_wr_en = 1'b0;
        end
        chk("clear_len", cnt, 640);
        chk("clear_dropped", 32'(bus.wr_dropped), 1);
        chk("clear_active", 32'(bus.active_render_buffer), 0);
        swap(1'b0);
        for (int i = 0; i < LEN; i++) rd(i, CV);

        // swap during clear restarts the clear on the other buffer
        swap(1'b1);
        cnt = 0;
        while (bus.renderer_ready == 1'b0 && cnt < 3000) begin
            cnt++;
            if (cnt == 100) begin
                bus.swap_req = 1'b1;
                bus.clear_en = 1'b1;
            end
            step();
            bus.swap_req = 1'b0;
            bus.clear_en = 1'b0;
        end
        chk("abort_len", cnt, 740);
        chk("abort_active", 32'(bus.active_render_buffer), 1);
        swap(1'b0);
        rd(60, CV);
        rd(3, CV);
        rd(4, CV);

        // reset during clear dominates swap
        swap(1'b1);
        for (int i = 0; i < 50; i++) step();
        chk("pre_rst_ready", 32'(bus.renderer_ready), 0);
        rst = 1'b1; bus.swap_req = 1'b1; bus.clear_en = 1'b1;
        step();
        rst = 1'b0; bus.swap_req = 1'b0; bus.clear_en = 1'b0;
        chk("rst_clr_ready", 32'(bus.renderer_ready), 1);
        chk("rst_clr_active", 32'(bus.active_render_buffer), 0);
        chk("rst_clr_dropped", 32'(bus.wr_dropped), 0);
        chk("rst_clr_rd_data", 32'(bus.composer_rd_data), 0);
        step();
        chk("rst_clr_ready2", 32'(bus.renderer_ready), 1);

        step(); step(); step();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
